// File: rtl/fc_spike_scheduler_pkg.sv
// Shared widths and helpers for the fully-connected spike scheduler slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef SYNAPSE_INDEX
`define SYNAPSE_INDEX 16
`endif
`ifndef CONV1_ADDR
`define CONV1_ADDR 10
`endif
`ifndef CHANNEL_WIDE
`define CHANNEL_WIDE 8
`endif

package fc_spike_scheduler_pkg;

    localparam int IDX_W  = `SYNAPSE_INDEX;
    localparam int ADDR_W = `CONV1_ADDR;
    localparam int CH_W   = `CHANNEL_WIDE;

    // Highest stored address for a given spike count; an empty list maps to 0.
    function automatic logic [ADDR_W-1:0] last_addr(input logic [ADDR_W-1:0] cnt);
        return (cnt == '0) ? '0 : cnt - 1'b1;
    endfunction

endpackage

// File: rtl/fc_spike_scheduler_if.sv
// Bundle of the scheduler's control, index-RAM and PE-facing signals.
// Latency: n/a (wiring only).
// Backpressure: pe_hold travels from the PE side back into the scheduler.
interface fc_spike_scheduler_if;
    import fc_spike_scheduler_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] spike_cnt;
    logic              idx_rd_en;
    logic [ADDR_W-1:0] idx_rd_addr;
    logic [IDX_W-1:0]  idx_rd_data;
    logic              pe_hold;
    logic [IDX_W-1:0]  s_index;
    logic              s_index_valid;
    logic [ADDR_W-1:0] addr_most;
    logic [CH_W-1:0]   cur_channel;
    logic              busy;
    logic              done;
    logic              idx_ram_release;

    // Scheduler side
    modport master (
        input  start, spike_cnt, idx_rd_data, pe_hold,
        output idx_rd_en, idx_rd_addr, s_index, s_index_valid,
               addr_most, cur_channel, busy, done, idx_ram_release
    );

    // Environment side: controller, index RAM and PE
    modport slave (
        output start, spike_cnt, idx_rd_data, pe_hold,
        input  idx_rd_en, idx_rd_addr, s_index, s_index_valid,
               addr_most, cur_channel, busy, done, idx_ram_release
    );
endinterface

// File: rtl/fc_spike_scheduler_idx_skid.sv
// Output register plus one-entry skid for RAM data caught in flight by pe_hold.
// Latency: 1 cycle from in_vld to out_vld when not held.
// Backpressure: hold suppresses out_vld next cycle; parked entry issues first on release.
module fc_idx_skid
    import fc_spike_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [IDX_W-1:0] in_dat,
    input  logic [CH_W-1:0]  in_ch,
    input  logic             hold,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_dat,
    output logic [CH_W-1:0]  out_ch,
    output logic             skid_full
);

    logic [IDX_W-1:0] skid_dat;
    logic [CH_W-1:0]  skid_ch;

    // Present the skid entry first, otherwise pass RAM data; park RAM data while held.
    // The scheduler stops reading while the skid is full, so in_vld never collides with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld   <= 1'b0;
            out_dat   <= '0;
            out_ch    <= '0;
            skid_full <= 1'b0;
            skid_dat  <= '0;
            skid_ch   <= '0;
        end else if (hold) begin
            out_vld <= 1'b0;
            if (in_vld) begin
                skid_full <= 1'b1;
                skid_dat  <= in_dat;
                skid_ch   <= in_ch;
            end
        end else if (skid_full) begin
            out_vld   <= 1'b1;
            out_dat   <= skid_dat;
            out_ch    <= skid_ch;
            skid_full <= 1'b0;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_dat <= in_dat;
                out_ch  <= in_ch;
            end
        end
    end

endmodule

// File: rtl/fc_spike_scheduler.sv
// Replays the stored spike-index list once per output channel into the PE.
// Latency: first s_index_valid 3 cycles after start; done PIPE_LAT+1 cycles after the last valid.
// Backpressure: pe_hold stops RAM reads; one in-flight read parks in the skid register.
module fc_spike_scheduler
    import fc_spike_scheduler_pkg::*;
#(
    parameter int OUTPUT_CHANNEL_NUM = 256,
    parameter int PIPE_LAT           = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fc_spike_scheduler_if.master bus
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    localparam logic [CH_W-1:0] CH_LAST    = CH_W'(OUTPUT_CHANNEL_NUM - 1);
    localparam int              DRAIN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

    state_t             state;
    logic [ADDR_W-1:0]  rd_addr;
    logic [CH_W-1:0]    rd_ch;
    logic               reads_done;
    logic               rd_vld_d;
    logic [CH_W-1:0]    rd_ch_d;
    logic [ADDR_W-1:0]  addr_most;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               busy;
    logic               done;
    logic               release_pulse;
    logic               rd_en;
    logic               skid_full;
    logic               out_vld;
    logic [IDX_W-1:0]   out_dat;
    logic [CH_W-1:0]    out_ch;

    assign rd_en = (state == STREAM) && !reads_done && !bus.pe_hold && !skid_full;

    assign bus.idx_rd_en       = rd_en;
    assign bus.idx_rd_addr     = rd_addr;
    assign bus.s_index         = out_dat;
    assign bus.s_index_valid   = out_vld;
    assign bus.cur_channel     = out_ch;
    assign bus.addr_most       = addr_most;
    assign bus.busy            = busy;
    assign bus.done            = done;
    assign bus.idx_ram_release = release_pulse;

    // Timestep sequencing: read address/channel walk, drain timer and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rd_addr       <= '0;
            rd_ch         <= '0;
            reads_done    <= 1'b0;
            rd_vld_d      <= 1'b0;
            rd_ch_d       <= '0;
            addr_most     <= '0;
            drain_cnt     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            // Channel tag follows the read so the PE sees the channel of the issued index.
            rd_vld_d      <= rd_en;
            rd_ch_d       <= rd_ch;
            done          <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rd_addr    <= '0;
                        rd_ch      <= '0;
                        reads_done <= 1'b0;
                        drain_cnt  <= '0;
                        addr_most  <= last_addr(bus.spike_cnt);
                        busy       <= 1'b1;
                        if (bus.spike_cnt == '0) begin
                            state         <= DONE;
                            done          <= 1'b1;
                            release_pulse <= 1'b1;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (rd_en) begin
                        if (rd_addr == addr_most) begin
                            rd_addr <= '0;
                            if (rd_ch == CH_LAST) begin
                                reads_done <= 1'b1;
                            end else begin
                                rd_ch <= rd_ch + 1'b1;
                            end
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                    // A valid with all reads done and nothing behind it is the final index.
                    if (reads_done && !rd_vld_d && !skid_full && out_vld) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        release_pulse <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fc_idx_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (rd_vld_d),
        .in_dat    (bus.idx_rd_data),
        .in_ch     (rd_ch_d),
        .hold      (bus.pe_hold),
        .out_vld   (out_vld),
        .out_dat   (out_dat),
        .out_ch    (out_ch),
        .skid_full (skid_full)
    );

endmodule

// File: doc/fc_spike_scheduler.md
FC_SPIKE_SCHEDULER -- requirements
Module: fc_spike_scheduler

Interface
REQ-001 SHALL have parameter OUTPUT_CHANNEL_NUM, default 256: number of output channels; every stored spike index is replayed once per channel.
REQ-002 SHALL have parameter PIPE_LAT, default 4: cycles from s_index_valid to the PE's mp_ready.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle timestep start pulse.
REQ-006 SHALL have port spike_cnt, input, `CONV1_ADDR: number of spike indices stored, sampled on an accepted start.
REQ-007 SHALL have port idx_rd_en, output, 1: index RAM read enable.
REQ-008 SHALL have port idx_rd_addr, output, `CONV1_ADDR: index RAM read address.
REQ-009 SHALL have port idx_rd_data, input, `SYNAPSE_INDEX: RAM data, valid exactly 1 cycle after idx_rd_en.
REQ-010 SHALL have port pe_hold, input, 1: downstream backpressure.
REQ-011 SHALL have port s_index, output, `SYNAPSE_INDEX: spike index to the PE.
REQ-012 SHALL have port s_index_valid, output, 1: qualifies s_index.
REQ-013 SHALL have port addr_most, output, `CONV1_ADDR: latched spike_cnt-1; 0 when spike_cnt==0.
REQ-014 SHALL have port cur_channel, output, `CHANNEL_WIDE: channel of the index currently presented.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse at the end of the timestep.
REQ-017 SHALL have port idx_ram_release, output, 1: one-cycle pulse coincident with done; the index RAM may then be overwritten.

Function
REQ-018 SHALL implement the states IDLE, STREAM, DRAIN and DONE.
REQ-019 IDLE: start with spike_cnt>0 at cycle t SHALL enter STREAM at t+1, with idx_rd_en=1 and idx_rd_addr=0 at t+1.
REQ-020 IDLE: start with spike_cnt==0 SHALL enter DONE at t+1; done and idx_ram_release SHALL pulse at t+1 with no s_index_valid.
REQ-021 STREAM: idx_rd_en = !pe_hold && skid empty; each read SHALL increment idx_rd_addr.
REQ-022 STREAM: on reaching addr spike_cnt-1, the next read SHALL wrap to 0 and increment the channel counter.
REQ-023 STREAM: the total read count SHALL be exactly spike_cnt*OUTPUT_CHANNEL_NUM.
REQ-024 s_index/s_index_valid SHALL be registered: read data at cycle c SHALL appear at c+1 when not held.
REQ-025 When pe_hold=1, no new s_index_valid SHALL be produced the next cycle; RAM data then in flight SHALL be captured in a 1-entry skid register.
REQ-026 On pe_hold release, the skid entry SHALL issue first; order SHALL be preserved, with no loss and no duplication.
REQ-027 cur_channel SHALL track the issued index, not the read address.
REQ-028 STREAM SHALL go to DRAIN once the final index has been presented.
REQ-029 DRAIN SHALL count PIPE_LAT cycles, then enter DONE; done SHALL pulse at last-valid cycle L + PIPE_LAT + 1.
REQ-030 DONE SHALL last one cycle, then return to IDLE.
REQ-031 start while busy SHALL be ignored, with no effect on counters.
REQ-032 Counters SHALL be sized from the `define widths.
REQ-033 The channel counter SHALL compare against OUTPUT_CHANNEL_NUM-1 and never exceed it.

Reset
REQ-034 rst SHALL force IDLE and clear addresses, counters, skid and s_index; idx_rd_en, s_index_valid, busy, done and idx_ram_release SHALL be 0 the cycle after rst.
REQ-035 rst mid-stream SHALL abort with no pending done; a start after reset release SHALL run normally.

Structure
REQ-036 Widths SHALL come from the shared define.vh (`SYNAPSE_INDEX, `CONV1_ADDR, `CHANNEL_WIDE); state encodings SHALL be module-local localparams.
REQ-037 The skid/output register SHALL be one sub-module, fc_idx_skid; the index RAM SHALL be external.

Verification
REQ-038 OUTPUT_CHANNEL_NUM=4, RAM={5,9,12}, spike_cnt=3 -> 12 valids in the sequence 5,9,12 x4; cur_channel 0..3; addr_most=2; done at last valid+5.
REQ-039 spike_cnt=0 -> done and idx_ram_release pulse 1 cycle after start; s_index_valid never asserts.
REQ-040 pe_hold high for 3 cycles at the 5th valid -> output sequence identical to REQ-038 with a 3-cycle gap, no duplicates.
REQ-041 start pulsed again mid-STREAM -> ignored; exactly 12 valids and one done.
REQ-042 rst asserted at the 7th valid -> all outputs 0 the next cycle; a fresh start then yields the full REQ-038 sequence.
REQ-043 spike_cnt=1, OUTPUT_CHANNEL_NUM=256 -> 256 valids of addr 0; cur_channel 0..255, no wrap past 255.
